// File: rtl/histogram_param.sv
// Streaming histogram with power-of-two bin widths, saturating per-bin counters,
// an out-of-range counter, a registered read port and a one-bin-per-cycle clear sweep.
module histogram_param #(
   parameter int DATA_W    = 6,
   parameter int BASE      = 17,
   parameter int BIN_SHIFT = 1,
   parameter int NUM_BINS  = 11,
   parameter int CNT_W     = 5,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              clear,
   output logic              busy,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_data,
   output logic [CNT_W-1:0]  oor_count,
   output logic              sat_flag
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_NEAR = CNT_MAX - 1'b1;
   localparam logic [DATA_W:0]   BASE_X   = (DATA_W+1)'(BASE);
   localparam logic [DATA_W:0]   NB_X     = (DATA_W+1)'(NUM_BINS);
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_BINS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [CNT_W-1:0]  cnt [NUM_BINS];
   logic [DATA_W:0]   offset, idx;
   logic              accept, in_range, oor_hit;
   logic [NUM_BINS-1:0] hit, hit_max;
   logic [CNT_W-1:0]  rd_mux;

   // One extra bit keeps values below BASE from wrapping into a valid bin.
   assign offset   = {1'b0, in_data} - BASE_X;
   assign idx      = offset >> BIN_SHIFT;
   assign in_range = ({1'b0, in_data} >= BASE_X) && (idx < NB_X);
   assign accept   = in_valid && (state == IDLE) && !clear;
   assign oor_hit  = accept && !in_range;

   for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
      assign hit[g]     = accept && in_range && (idx == (DATA_W+1)'(g));
      assign hit_max[g] = hit[g] && (cnt[g] == CNT_NEAR);

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            cnt[g] <= '0;
         else if (state == CLEAR && ptr == ADDR_W'(g))
            cnt[g] <= '0;
         else if (hit[g] && cnt[g] != CNT_MAX)
            cnt[g] <= cnt[g] + 1'b1;
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_BINS; i++)
         if (rd_addr == ADDR_W'(i)) rd_mux = cnt[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         busy      <= 1'b0;
         oor_count <= '0;
         sat_flag  <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         rd_valid <= rd_en;
         // Bins are mid-sweep while busy, so reads report zero rather than stale counts.
         if (rd_en) rd_data <= (state == CLEAR) ? '0 : rd_mux;
         case (state)
            IDLE: begin
               if (clear) begin
                  state     <= CLEAR;
                  busy      <= 1'b1;
                  ptr       <= '0;
                  oor_count <= '0;
                  sat_flag  <= 1'b0;
               end else begin
                  if (oor_hit && oor_count != CNT_MAX)
                     oor_count <= oor_count + 1'b1;
                  if ((|hit_max) || (oor_hit && oor_count == CNT_NEAR))
                     sat_flag <= 1'b1;
               end
            end
            CLEAR: begin
               ptr <= ptr + 1'b1;
               if (ptr == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_histogram_param.sv
// Directed bench for histogram_param at default parameters.
module tb_histogram_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [5:0] in_data;
   logic       clear;
   logic       busy;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic       rd_valid;
   logic [4:0] rd_data;
   logic [4:0] oor_count;
   logic       sat_flag;

   int pass_cnt = 0;
   int total    = 0;
   int busy_cyc;

   histogram_param dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .clear(clear), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data), .oor_count(oor_count),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic feed(input int v);
      in_valid = 1'b1;
      in_data  = 6'(v);
      step();
      in_valid = 1'b0;
   endtask

   task automatic rd(input int a, input int exp, input string tag);
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      step();
      rd_en = 1'b0;
      chk({tag, "_vld"}, 32'(rd_valid), 1);
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
      step(); step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdv", 32'(rd_valid), 0);
      chk("rst_oor", 32'(oor_count), 0);
      chk("rst_sat", 32'(sat_flag), 0);
      rst = 1'b0;

      // Back-to-back reads of every address, including those beyond the bins.
      for (int a = 0; a < 16; a++) rd(a, 0, "init_rd");
      step();
      chk("rdv_idle", 32'(rd_valid), 0);

      feed(17); feed(18); feed(18); feed(38); feed(29);
      rd(0, 3, "bin0");
      rd(10, 1, "bin10");
      rd(6, 1, "bin6");
      rd(1, 0, "bin1");
      rd(8, 0, "bin8_pre");
      chk("oor_zero", 32'(oor_count), 0);

      feed(16); feed(39); feed(63); feed(0);
      chk("oor_four", 32'(oor_count), 4);
      rd(0, 3, "bin0_after_oor");
      rd(10, 1, "bin10_after_oor");

      for (int i = 1; i <= 35; i++) begin
         feed(33);
         if (i == 30) chk("sat_before", 32'(sat_flag), 0);
         if (i == 31) chk("sat_rise", 32'(sat_flag), 1);
      end
      rd(8, 31, "bin8_sat");
      chk("sat_sticky", 32'(sat_flag), 1);
      chk("oor_unchanged", 32'(oor_count), 4);

      // Clear with a sample every cycle; a second clear and a read land mid-sweep.
      in_valid = 1'b1; in_data = 6'd20; clear = 1'b1;
      step();
      clear = 1'b0;
      busy_cyc = 0;
      for (int k = 0; k < 20; k++) begin
         if (k == 0) begin
            chk("clr_oor", 32'(oor_count), 0);
            chk("clr_sat", 32'(sat_flag), 0);
         end
         if (k == 3) clear = 1'b1;
         if (k == 4) clear = 1'b0;
         if (k == 5) begin rd_en = 1'b1; rd_addr = 4'd8; end
         if (k == 6) begin
            rd_en = 1'b0;
            chk("busy_rd_vld", 32'(rd_valid), 1);
            chk("busy_rd_data", 32'(rd_data), 0);
         end
         if (!busy) break;
         busy_cyc++;
         step();
      end
      in_valid = 1'b0;
      chk("busy_len", 32'(busy_cyc), 11);
      chk("post_clr_oor", 32'(oor_count), 0);
      chk("post_clr_sat", 32'(sat_flag), 0);
      for (int a = 0; a < 11; a++) rd(a, 0, "post_clr_bin");
      feed(20);
      rd(1, 1, "bin1_after_clr");

      // Populate, then reset in the fifth cycle of a sweep.
      feed(33); feed(33); feed(33); feed(5); feed(50);
      chk("oor_two", 32'(oor_count), 2);
      clear = 1'b1;
      step();
      clear = 1'b0;
      step(); step(); step(); step();
      chk("mid_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      chk("rst_async_busy", 32'(busy), 0);
      step();
      rst = 1'b0;
      chk("rst_mid_oor", 32'(oor_count), 0);
      chk("rst_mid_sat", 32'(sat_flag), 0);
      chk("rst_mid_rdv", 32'(rd_valid), 0);
      rd(8, 0, "rst_mid_bin8");
      rd(1, 0, "rst_mid_bin1");

      // Read and increment of the same bin at one edge, then again next edge.
      in_valid = 1'b1; in_data = 6'd25; rd_en = 1'b1; rd_addr = 4'd4;
      step();
      in_valid = 1'b0;
      chk("same_edge_vld", 32'(rd_valid), 1);
      chk("same_edge_old", 32'(rd_data), 0);
      step();
      rd_en = 1'b0;
      chk("next_edge_new", 32'(rd_data), 1);
      step();
      chk("rdv_drop", 32'(rd_valid), 0);
      chk("rd_hold", 32'(rd_data), 1);
      rd(13, 0, "addr_oob");

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
